piso_tx_ctrl: RTL and testbench
===============================

Name: piso_tx_ctrl

Overview:
Sequencer for a parallel-in/serial-out shift register. It accepts a WIDTH-bit word on a valid/ready handshake, loads it into the shift register, and shifts it out one bit per accepted serial beat under downstream backpressure. It also marks frame boundaries. It sits between a parallel word producer and a bit-serial sink such as a link or a serial pin driver.

Parameters:
WIDTH, 4, bits per word and serial frame length; must be at least 2.
MSB_FIRST, 0, 0 shifts out bit 0 first; 1 shifts out bit WIDTH-1 first.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
in_data  input  WIDTH  parallel word to serialize.
in_valid  input  1  in_data is valid.
in_ready  output  1  controller accepts in_data this cycle.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out is valid.
ser_ready  input  1  sink consumes ser_out this cycle.
frame_start  output  1  ser_out is the first bit of a frame (qualified by ser_valid).
frame_end  output  1  ser_out is the last bit of a frame (qualified by ser_valid).
busy  output  1  a frame is in progress.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high: sampled only on a rising clk edge, and it overrides all other inputs.
- Reset values, registered:
  - state = IDLE, bit counter = 0, shift register = 0.
  - Resulting outputs: ser_valid = 0, busy = 0, frame_start = 0, frame_end = 0, ser_out = 0.
  - in_ready = 1 from the first cycle after reset release.
- States: IDLE, SHIFT. Two-state FSM, registered state.
- IDLE:
  - in_ready = 1, ser_valid = 0.
  - An input handshake is in_valid && in_ready. On it, load in_data into the shift register, clear the counter to 0, and go to SHIFT.
  - Latency from input handshake to first ser_valid is 1 cycle.
- SHIFT:
  - ser_valid = 1, busy = 1.
  - ser_out = shreg[0] when MSB_FIRST = 0, otherwise shreg[WIDTH-1].
  - frame_start = (count == 0). frame_end = (count == WIDTH-1).
  - A serial beat is ser_valid && ser_ready. On a beat, shift the register by one position toward the output end, fill with 0, and increment count.
  - If ser_ready = 0, shreg, count and all outputs hold.
- Last-bit rules (count == WIDTH-1 with a serial beat):
  - in_ready = 1 in that cycle. in_ready is combinational on ser_ready in this case only.
  - If in_valid = 1: load the new word, set count = 0, stay in SHIFT. This gives zero-gap back-to-back frames.
  - Otherwise go to IDLE.
- In SHIFT outside the last-bit case, in_ready = 0. in_valid is ignored and in_data must not be captured.
- Counter width is clog2(WIDTH). The counter never wraps past WIDTH-1; the last-bit rule resets it.
- in_data is sampled only on the handshake edge. Later changes do not affect the frame in flight.
- Reset mid-frame: the frame is aborted and no further bits are emitted. The cycle after the reset edge shows reset values, including ser_valid = 0.
- With in_valid = 1 and rst = 1 on the same edge, reset wins and the word is not accepted.
- No combinational path from in_valid or in_data to any output except in_ready. The in_ready dependence on ser_ready exists only in the last-bit case.

Decomposition:
- Shared package piso_pkg holds:
  - the state encoding constants ST_IDLE = 1'b0 and ST_SHIFT = 1'b1;
  - a function computing counter width from WIDTH.
- Sub-module piso_shreg: WIDTH-bit register with synchronous rst, load (parallel capture), shift_en, and a direction parameter. It exposes the serial output bit.
- piso_tx_ctrl instantiates one piso_shreg and owns the FSM, counter, handshakes and frame flags.

Test Plan:
1. Reset/idle: assert rst for 3 cycles with in_valid = 1 -> during and one cycle after reset, ser_valid = 0, busy = 0, and no word is accepted; in_ready = 1 after release.
2. Single frame, WIDTH = 4, MSB_FIRST = 0, ser_ready tied high: in_data = 4'b1011 -> ser_out = 1, 1, 0, 1 on 4 consecutive cycles. frame_start is set on the first beat only, frame_end on the fourth only, then ser_valid = 0.
3. Backpressure: same word, ser_ready = 0 for 2 cycles after the first bit -> bit 1 is held with frame_start held for those cycles. The total sequence is still 1, 1, 0, 1, and frame length extends by 2 cycles.
4. Back-to-back: in_valid held with 4'b1011 then 4'b0110, ser_ready high -> 8 contiguous valid bits 1, 1, 0, 1, 0, 1, 1, 0. in_ready pulses on the last-bit cycle, and frame_start is set on beats 1 and 5.
5. Busy ignore: present 4'b1111 with in_valid during bits 1–2 of a frame -> not captured, and the in-flight frame is unchanged.
6. Reset mid-frame: rst on the third bit -> the next cycle shows ser_valid = 0 and busy = 0. A new word 4'b0001 then serializes as 1, 0, 0, 0 with MSB_FIRST = 0, and as 0, 0, 0, 1 with MSB_FIRST = 1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmit sequencer:
// FSM state encoding and bit-counter sizing.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load shift register; shifts toward the output end,
// filling with zero.
module piso_shreg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else if (load_i) begin
      sh_q <= data_i;
    end else if (shift_en_i) begin
      if (MSB_FIRST) sh_q <= {sh_q[WIDTH-2:0], 1'b0};
      else           sh_q <= {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  assign ser_o = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Word-to-bit serializer sequencer with valid/ready on both
// sides and zero-gap back-to-back frames.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          shift_st;
  logic          last;
  logic          beat;
  logic          accept;

  assign shift_st = (state_q == ST_SHIFT);
  assign last     = shift_st && (cnt_q == LAST);
  assign beat     = shift_st && ser_ready;
  // Only the final beat of a frame opens the input early.
  assign in_ready = !shift_st || (last && ser_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (beat) begin
            if (last) begin
              cnt_q <= '0;
              if (!in_valid) state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .shift_en_i (beat && !accept),
    .data_i     (in_data),
    .ser_o      (ser_out)
  );

  assign ser_valid   = shift_st;
  assign busy        = shift_st;
  assign frame_start = shift_st && (cnt_q == '0);
  assign frame_end   = last;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: LSB-first and MSB-first instances
// driven in parallel and compared to a word/remaining-bits model.
module tb_piso_tx_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         ser_ready;

  logic rdy0, so0, sv0, fs0, fe0, b0;
  logic rdy1, so1, sv1, fs1, fe1, b1;

  int checks = 0;
  int errors = 0;

  // Model: word in flight and number of its bits not yet consumed.
  logic [W-1:0] m_word = '0;
  int           m_rem  = 0;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (rdy0),
    .ser_out     (so0),
    .ser_valid   (sv0),
    .ser_ready   (ser_ready),
    .frame_start (fs0),
    .frame_end   (fe0),
    .busy        (b0)
  );

  piso_tx_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (rdy1),
    .ser_out     (so1),
    .ser_valid   (sv1),
    .ser_ready   (ser_ready),
    .frame_start (fs1),
    .frame_end   (fe1),
    .busy        (b1)
  );

  task automatic chk(input string tag, input logic obs,
                     input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  function automatic logic exp_rdy();
    return (m_rem == 0) || (m_rem == 1 && ser_ready);
  endfunction

  // One clock: apply inputs, check at negedge, advance model at posedge.
  task automatic step(input logic r, input logic iv,
                      input logic [W-1:0] d, input logic sr);
    logic act, xl, xm, acc;
    int   p;
    rst = r; in_valid = iv; in_data = d; ser_ready = sr;
    @(negedge clk);
    act = (m_rem != 0);
    p   = W - m_rem;
    xl  = act ? m_word[p] : 1'b0;
    xm  = act ? m_word[W-1-p] : 1'b0;
    chk("ser_valid_lsb", sv0, act);
    chk("ser_valid_msb", sv1, act);
    chk("busy_lsb", b0, act);
    chk("busy_msb", b1, act);
    chk("ser_out_lsb", so0, xl);
    chk("ser_out_msb", so1, xm);
    chk("frame_start", fs0, act && m_rem == W);
    chk("frame_start_msb", fs1, act && m_rem == W);
    chk("frame_end", fe0, m_rem == 1);
    chk("frame_end_msb", fe1, m_rem == 1);
    if (!r) begin
      chk("in_ready_lsb", rdy0, exp_rdy());
      chk("in_ready_msb", rdy1, exp_rdy());
    end
    acc = iv && exp_rdy();
    @(posedge clk);
    if (r) begin
      m_rem  = 0;
      m_word = '0;
    end else begin
      if (m_rem != 0 && sr) m_rem--;
      if (acc) begin
        m_word = d;
        m_rem  = W;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 4'hA; ser_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset held with a valid word offered
    repeat (3) step(1'b1, 1'b1, 4'hA, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    // Single frame
    step(1'b0, 1'b1, 4'b1011, 1'b1);
    repeat (5) step(1'b0, 1'b0, 4'($urandom), 1'b1);
    // Backpressure after the first bit
    step(1'b0, 1'b1, 4'b1011, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 4'h0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 4'h0, 1'b1);
    // Back-to-back frames
    repeat (4) step(1'b0, 1'b1, 4'b1011, 1'b1);
    repeat (4) step(1'b0, 1'b1, 4'b0110, 1'b1);
    repeat (2) step(1'b0, 1'b0, 4'h0, 1'b1);
    // Offer a word while busy
    step(1'b0, 1'b1, 4'b0101, 1'b1);
    repeat (2) step(1'b0, 1'b1, 4'hF, 1'b1);
    repeat (4) step(1'b0, 1'b0, 4'hF, 1'b1);
    // Reset mid-frame, then a fresh word
    step(1'b0, 1'b1, 4'b1011, 1'b1);
    repeat (2) step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 4'b0001, 1'b1);
    repeat (5) step(1'b0, 1'b0, 4'h0, 1'b1);
    // Reset and valid on the same edge
    step(1'b1, 1'b1, 4'hC, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    // Random traffic
    repeat (400) begin
      step(($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)),
           4'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
